// File: rtl/load_queue.sv
// In-order load queue: allocate, wait for ROB ready, issue one load at a time,
// extend returned data and write it back; flush drains any in-flight access.
module load_queue #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_en_in,
  input  logic [ADDR_W-1:0] alloc_addr_in,
  input  logic [ROB_W-1:0]  alloc_dest_in,
  input  logic [2:0]        alloc_width_in,
  input  logic              alloc_sgn_in,
  output logic              full_out,
  output logic              rob_alloc_valid_out,
  output logic [ROB_W-1:0]  rob_alloc_dest_out,
  output logic [IDX_W-1:0]  rob_alloc_idx_out,
  input  logic              rob_ready_en_in,
  input  logic [IDX_W-1:0]  rob_ready_idx_in,
  input  logic              rob_flush_in,
  output logic              rob_wb_valid_out,
  output logic [ROB_W-1:0]  rob_wb_dest_out,
  output logic [DATA_W-1:0] rob_wb_value_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [2:0]        mem_width_out,
  input  logic              mem_done_in,
  input  logic [DATA_W-1:0] mem_data_in
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DEPTH-1:0]  sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [ROB_W-1:0]  dest_q [DEPTH];
  logic [ROB_W-1:0]  dest_d [DEPTH];
  logic [2:0]        width_q [DEPTH];
  logic [2:0]        width_d [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [2:0]        mwidth_q, mwidth_d;

  logic              alloc_vld_q, alloc_vld_d;
  logic [ROB_W-1:0]  alloc_dest_q, alloc_dest_d;
  logic [IDX_W-1:0]  alloc_idx_q, alloc_idx_d;

  logic              wb_vld_q, wb_vld_d;
  logic [ROB_W-1:0]  wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_val_q, wb_val_d;

  logic alloc_fire;
  logic pop;

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] d,
    input logic [2:0]        w,
    input logic              s
  );
    logic [DATA_W-1:0] r;
    r = d;
    case (w)
      3'b001:  r = {{(DATA_W-8){s & d[7]}}, d[7:0]};
      3'b010:  r = {{(DATA_W-16){s & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign full_out = (count_q == FULL_CNT);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    ready_d      = ready_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    dest_d       = dest_q;
    width_d      = width_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    req_d        = req_q;
    maddr_d      = maddr_q;
    mwidth_d     = mwidth_q;
    alloc_vld_d  = 1'b0;
    alloc_dest_d = alloc_dest_q;
    alloc_idx_d  = alloc_idx_q;
    wb_vld_d     = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_val_d     = wb_val_q;
    alloc_fire   = 1'b0;
    pop          = 1'b0;

    if (rdy_in) begin
      alloc_fire = alloc_en_in && !full_out && !rob_flush_in;

      if (rob_ready_en_in && valid_q[rob_ready_idx_in])
        ready_d[rob_ready_idx_in] = 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (!rob_flush_in && valid_q[head_q] && ready_q[head_q]) begin
            req_d    = 1'b1;
            maddr_d  = addr_q[head_q];
            mwidth_d = width_q[head_q];
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done_in) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
            if (!rob_flush_in) begin
              pop       = 1'b1;
              wb_vld_d  = 1'b1;
              wb_dest_d = dest_q[head_q];
              wb_val_d  = extend(mem_data_in, width_q[head_q],
                                 sgn_q[head_q]);
            end
          end else if (rob_flush_in) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_done_in) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      endcase

      if (pop) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end

      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        addr_d[tail_q]  = alloc_addr_in;
        dest_d[tail_q]  = alloc_dest_in;
        width_d[tail_q] = alloc_width_in;
        sgn_d[tail_q]   = alloc_sgn_in;
        tail_d          = tail_q + IDX_W'(1);
        alloc_vld_d     = 1'b1;
        alloc_dest_d    = alloc_dest_in;
        alloc_idx_d     = tail_q;
      end

      case ({alloc_fire, pop})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase

      // Flush empties the queue; an in-flight access is left to drain.
      if (rob_flush_in) begin
        valid_d = '0;
        ready_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      ready_q      <= '0;
      sgn_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        dest_q[i]  <= '0;
        width_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      req_q        <= 1'b0;
      maddr_q      <= '0;
      mwidth_q     <= '0;
      alloc_vld_q  <= 1'b0;
      alloc_dest_q <= '0;
      alloc_idx_q  <= '0;
      wb_vld_q     <= 1'b0;
      wb_dest_q    <= '0;
      wb_val_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      dest_q       <= dest_d;
      width_q      <= width_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      req_q        <= req_d;
      maddr_q      <= maddr_d;
      mwidth_q     <= mwidth_d;
      alloc_vld_q  <= alloc_vld_d;
      alloc_dest_q <= alloc_dest_d;
      alloc_idx_q  <= alloc_idx_d;
      wb_vld_q     <= wb_vld_d;
      wb_dest_q    <= wb_dest_d;
      wb_val_q     <= wb_val_d;
    end
  end

  assign rob_alloc_valid_out = alloc_vld_q & rdy_in;
  assign rob_alloc_dest_out  = alloc_dest_q;
  assign rob_alloc_idx_out   = alloc_idx_q;
  assign rob_wb_valid_out    = wb_vld_q & rdy_in;
  assign rob_wb_dest_out     = wb_dest_q;
  assign rob_wb_value_out    = wb_val_q;
  assign mem_req_out         = req_q;
  assign mem_addr_out        = maddr_q;
  assign mem_width_out       = mwidth_q;

endmodule

// File: tb/tb_load_queue.sv
// Scoreboard bench for load_queue: stimulus pushes expectations,
// a negedge monitor pops and compares alloc, writeback and request events.
module tb_load_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_en;
  logic [31:0] alloc_addr;
  logic [3:0]  alloc_dest;
  logic [2:0]  alloc_width;
  logic        alloc_sgn;
  logic        full;
  logic        a_vld;
  logic [3:0]  a_dest;
  logic [2:0]  a_idx;
  logic        r_en;
  logic [2:0]  r_idx;
  logic        flush;
  logic        wb_vld;
  logic [3:0]  wb_dest;
  logic [31:0] wb_val;
  logic        req;
  logic [31:0] maddr;
  logic [2:0]  mwidth;
  logic        done;
  logic [31:0] mdata;

  int total = 0;
  int bad   = 0;

  logic [6:0]  exp_alloc [$];
  logic [35:0] exp_wb    [$];
  logic [34:0] exp_mem   [$];
  logic        req_prev = 1'b0;

  load_queue dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .rdy_in              (rdy),
    .alloc_en_in         (alloc_en),
    .alloc_addr_in       (alloc_addr),
    .alloc_dest_in       (alloc_dest),
    .alloc_width_in      (alloc_width),
    .alloc_sgn_in        (alloc_sgn),
    .full_out            (full),
    .rob_alloc_valid_out (a_vld),
    .rob_alloc_dest_out  (a_dest),
    .rob_alloc_idx_out   (a_idx),
    .rob_ready_en_in     (r_en),
    .rob_ready_idx_in    (r_idx),
    .rob_flush_in        (flush),
    .rob_wb_valid_out    (wb_vld),
    .rob_wb_dest_out     (wb_dest),
    .rob_wb_value_out    (wb_val),
    .mem_req_out         (req),
    .mem_addr_out        (maddr),
    .mem_width_out       (mwidth),
    .mem_done_in         (done),
    .mem_data_in         (mdata)
  );

  always #5 clk = ~clk;

  // monitor
  always @(negedge clk) begin
    logic [6:0]  ea;
    logic [35:0] ew;
    logic [34:0] em;
    if (!rst) begin
      if (a_vld) begin
        total++;
        if (exp_alloc.size() == 0) begin
          bad++;
          $display("FAIL alloc_pulse: unexpected dest=%0d idx=%0d",
                   a_dest, a_idx);
        end else begin
          ea = exp_alloc.pop_front();
          if ({a_dest, a_idx} !== ea) begin
            bad++;
            $display("FAIL alloc_pulse: got dest=%0d idx=%0d want dest=%0d idx=%0d",
                     a_dest, a_idx, ea[6:3], ea[2:0]);
          end
        end
      end
      if (wb_vld) begin
        total++;
        if (exp_wb.size() == 0) begin
          bad++;
          $display("FAIL writeback: unexpected dest=%0d val=%h",
                   wb_dest, wb_val);
        end else begin
          ew = exp_wb.pop_front();
          if ({wb_dest, wb_val} !== ew) begin
            bad++;
            $display("FAIL writeback: got dest=%0d val=%h want dest=%0d val=%h",
                     wb_dest, wb_val, ew[35:32], ew[31:0]);
          end
        end
      end
      if (req && !req_prev) begin
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_req: unexpected addr=%h width=%b", maddr, mwidth);
        end else begin
          em = exp_mem.pop_front();
          if ({maddr, mwidth} !== em) begin
            bad++;
            $display("FAIL mem_req: got addr=%h width=%b want addr=%h width=%b",
                     maddr, mwidth, em[34:3], em[2:0]);
          end
        end
      end
      req_prev = req;
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_alloc(input logic [31:0] a, input logic [3:0] d,
                          input logic [2:0] w, input logic s,
                          input logic [2:0] idx, input logic expect_ok);
    alloc_en    = 1'b1;
    alloc_addr  = a;
    alloc_dest  = d;
    alloc_width = w;
    alloc_sgn   = s;
    if (expect_ok) exp_alloc.push_back({d, idx});
    tick();
    alloc_en = 1'b0;
  endtask

  task automatic do_ready(input logic [2:0] idx);
    r_en  = 1'b1;
    r_idx = idx;
    tick();
    r_en  = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    if (!req) begin
      total++;
      bad++;
      $display("FAIL wait_req: timeout req=%b want 1", req);
    end
  endtask

  task automatic do_done(input logic [31:0] d);
    wait_req();
    done  = 1'b1;
    mdata = d;
    tick();
    done  = 1'b0;
  endtask

  logic [2:0]  t_w [8];
  logic        t_s [8];
  logic [31:0] t_d [8];
  logic [31:0] t_v [8];

  initial begin
    t_w[0] = 3'b100; t_s[0] = 0; t_d[0] = 32'h12345678; t_v[0] = 32'h12345678;
    t_w[1] = 3'b001; t_s[1] = 0; t_d[1] = 32'h000000FF; t_v[1] = 32'h000000FF;
    t_w[2] = 3'b001; t_s[2] = 1; t_d[2] = 32'h0000007F; t_v[2] = 32'h0000007F;
    t_w[3] = 3'b010; t_s[3] = 1; t_d[3] = 32'h0000FFFE; t_v[3] = 32'hFFFFFFFE;
    t_w[4] = 3'b010; t_s[4] = 0; t_d[4] = 32'h00008000; t_v[4] = 32'h00008000;
    t_w[5] = 3'b100; t_s[5] = 1; t_d[5] = 32'h80000000; t_v[5] = 32'h80000000;
    t_w[6] = 3'b001; t_s[6] = 1; t_d[6] = 32'h00000080; t_v[6] = 32'hFFFFFF80;
    t_w[7] = 3'b010; t_s[7] = 1; t_d[7] = 32'h00007FFF; t_v[7] = 32'h00007FFF;

    rst = 1'b1; rdy = 1'b1; alloc_en = 1'b0; alloc_addr = '0;
    alloc_dest = '0; alloc_width = '0; alloc_sgn = 1'b0;
    r_en = 1'b0; r_idx = '0; flush = 1'b0; done = 1'b0; mdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_full", full, 0);
    chk("reset_alloc_vld", a_vld, 0);
    chk("reset_wb_vld", wb_vld, 0);
    chk("reset_req", req, 0);
    chk("reset_maddr", maddr, 0);
    chk("reset_wb_val", wb_val, 0);

    // single sign-extended byte load
    do_alloc(32'h100, 4'd5, 3'b001, 1'b1, 3'd0, 1'b1);
    do_ready(3'd0);
    exp_mem.push_back({32'h100, 3'b001});
    exp_wb.push_back({4'd5, 32'hFFFFFFF0});
    do_done(32'h000000F0);
    tick();

    // zero-extended half with garbage upper bits
    do_alloc(32'h200, 4'd6, 3'b010, 1'b0, 3'd1, 1'b1);
    do_ready(3'd1);
    exp_mem.push_back({32'h200, 3'b010});
    exp_wb.push_back({4'd6, 32'h00008001});
    do_done(32'hABCD8001);
    tick();

    // fill all eight slots starting at slot 2, wrap through 0
    for (int k = 0; k < 8; k++) begin
      do_alloc(32'h1000 + 32'(k * 4), 4'(k + 1), t_w[k], t_s[k],
               3'(k + 2), 1'b1);
      exp_mem.push_back({32'h1000 + 32'(k * 4), t_w[k]});
      exp_wb.push_back({4'(k + 1), t_v[k]});
    end
    chk("full_after_8", full, 1);
    do_alloc(32'hDEAD, 4'd15, 3'b100, 1'b0, 3'd0, 1'b0);
    chk("full_after_9th", full, 1);
    for (int k = 0; k < 8; k++) do_ready(3'(k));
    for (int k = 0; k < 8; k++) do_done(t_d[k]);
    tick();
    chk("empty_after_drain", full, 0);

    // out-of-order ready: tail must be back at slot 2
    do_alloc(32'h300, 4'd9, 3'b100, 1'b0, 3'd2, 1'b1);
    do_alloc(32'h304, 4'd10, 3'b100, 1'b0, 3'd3, 1'b1);
    do_ready(3'd3);
    tick(); tick(); tick();
    chk("ooo_no_req", req, 0);
    exp_mem.push_back({32'h300, 3'b100});
    exp_wb.push_back({4'd9, 32'h11111111});
    exp_mem.push_back({32'h304, 3'b100});
    exp_wb.push_back({4'd10, 32'h22222222});
    do_ready(3'd2);
    do_done(32'h11111111);
    do_done(32'h22222222);
    tick();

    // flush during WAIT, with a same-cycle alloc that must be dropped
    do_alloc(32'h400, 4'd11, 3'b100, 1'b0, 3'd4, 1'b1);
    do_ready(3'd4);
    exp_mem.push_back({32'h400, 3'b100});
    wait_req();
    flush = 1'b1;
    alloc_en = 1'b1; alloc_addr = 32'h500; alloc_dest = 4'd12;
    tick();
    flush = 1'b0;
    alloc_en = 1'b0;
    chk("drain_req_held", req, 1);
    done = 1'b1; mdata = 32'hCAFEBABE;
    tick();
    done = 1'b0;
    chk("drain_req_low", req, 0);
    chk("flush_not_full", full, 0);
    tick(); tick();
    chk("flush_idle_no_req", req, 0);
    do_alloc(32'h600, 4'd13, 3'b001, 1'b0, 3'd0, 1'b1);
    do_ready(3'd0);
    exp_mem.push_back({32'h600, 3'b001});
    exp_wb.push_back({4'd13, 32'h000000AB});
    do_done(32'h123456AB);
    tick();

    // rdy low for three cycles while waiting
    do_alloc(32'h700, 4'd14, 3'b010, 1'b1, 3'd1, 1'b1);
    do_ready(3'd1);
    exp_mem.push_back({32'h700, 3'b010});
    exp_wb.push_back({4'd14, 32'hFFFF9000});
    wait_req();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rdy_low_req_held", req, 1);
    end
    rdy = 1'b1;
    do_done(32'h00009000);
    tick(); tick(); tick();

    chk("alloc_queue_empty", 64'(exp_alloc.size()), 0);
    chk("wb_queue_empty", 64'(exp_wb.size()), 0);
    chk("mem_queue_empty", 64'(exp_mem.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
